calc_driver: RTL and testbench
==============================

CALC_DRIVER -- requirements
Module: calc_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the response FIFO entries (power of two, >=4).
REQ-002 Parameter CALC_LATENCY, default 2, SHALL set the calculator's input-to-output register depth in cycles.
REQ-003 Port clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port req_valid  in  1  SHALL mean a request is offered.
REQ-006 Port req_ready  out  1  SHALL mean a request is accepted this cycle.
REQ-007 Port req_op  in  2  SHALL carry the opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 Ports req_a and req_b  in  8 signed  SHALL carry the operands.
REQ-009 Port req_tag  in  4  SHALL carry a request identifier, returned unchanged.
REQ-010 Ports calc_function_out  out  2, calc_a_out  out  8, calc_b_out  out  8  SHALL drive the calculator inputs.
REQ-011 Port calc_result_in  in  16 signed  SHALL receive the calculator output.
REQ-012 Port rsp_valid  out  1  SHALL mean a response is presented; rsp_ready  in  1  SHALL mean it is consumed.
REQ-013 Ports rsp_result  out  16 signed, rsp_tag  out  4, rsp_dbz  out  1  SHALL carry the result, the tag and a divide-by-zero flag.
REQ-014 Port flush  in  1  SHALL request a drain; busy  out  1  SHALL flag in-flight or buffered work.

Function
REQ-015 A transfer SHALL occur at a rising edge where req_valid && req_ready; a response pops at an edge where rsp_valid && rsp_ready.
REQ-016 calc_* outputs SHALL be registered: they carry the accepted op/a/b from acceptance edge E until the next edge, otherwise 00/0/0.
REQ-017 A tracking shift register CALC_LATENCY+1 deep SHALL carry {valid, tag, dbz} per issue slot, one stage per cycle.
REQ-018 calc_result_in SHALL be captured into the FIFO at edge E+CALC_LATENCY+1 (E+3 by default) with its tag and dbz; results of idle slots SHALL be discarded.
REQ-019 rsp_dbz SHALL be 1 iff req_op==11 and req_b==0 at acceptance; rsp_result SHALL then be the calculator's saturated value.
REQ-020 Credit rule: req_ready SHALL be 1 only when state==RUN, flush==0 and fifo_count + inflight_count < FIFO_DEPTH; a pop in the same cycle SHALL NOT add credit.
REQ-021 Maximum accept rate SHALL be one request per cycle; responses SHALL leave in acceptance order.
REQ-022 FIFO outputs SHALL be first-word-fall-through; rsp_* SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 Simultaneous capture and pop SHALL leave fifo_count unchanged; the FIFO SHALL never overflow (guaranteed by REQ-020).
REQ-024 FSM states SHALL be RUN and DRAIN; RUN->DRAIN on flush==1; DRAIN->RUN when inflight_count==0 and the FIFO is empty.
REQ-025 In DRAIN, no request SHALL be accepted, and in-flight results SHALL still be captured and delivered.
REQ-026 flush and req_valid asserted in the same cycle SHALL NOT accept the request.
REQ-027 busy SHALL equal (inflight_count != 0) || (fifo_count != 0).

Reset
REQ-028 While rst_n==0, the block SHALL hold: state RUN, req_ready 0, calc_* outputs 0, rsp_valid 0, rsp_result/rsp_tag/rsp_dbz 0, busy 0, tracking register and FIFO empty.
REQ-029 Reset asserted mid-operation SHALL drop all in-flight and buffered responses; req_ready SHALL rise in the first cycle after release.

Structure
REQ-030 Package calc_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the operand width 8, the result width 16, the tag width 4 and the response struct {result, tag, dbz}.
REQ-031 The response FIFO SHALL be sub-module calc_rsp_fifo (parameterised depth, FWFT, count output).
REQ-032 Expected size SHALL be 150-300 lines of RTL.

Verification
REQ-033 Each scenario SHALL run with calc_driver connected to the real calculator and rsp_ready=1 unless stated. Add 100+27, tag 3: response 127, tag 3, dbz 0 visible after edge E+3.
REQ-034 Back-to-back mul -128*-128, then sub -128-127, then div -7/2 SHALL return 16384, -255, -3 in order on consecutive cycles.
REQ-035 Div 7/0 SHALL return 32767 with dbz 1; div -5/0 SHALL return -32768 with dbz 1.
REQ-036 With rsp_ready=0 and continuous requests, req_ready SHALL fall after exactly 8 accepts; raising rsp_ready SHALL deliver all 8 in order.
REQ-037 flush pulsed with 3 requests in flight SHALL deliver 3 responses; req_ready SHALL stay 0 until busy==0, then RUN resumes.
REQ-038 rst_n pulsed low with 2 in flight SHALL produce no responses; a fresh request SHALL complete normally after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator driver and its response FIFO.
package calc_pkg;
   localparam int OPND_W = 8;
   localparam int RES_W  = 16;
   localparam int TAG_W  = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } calc_op_e;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } drv_state_e;

   typedef struct packed {
      logic signed [RES_W-1:0] result;
      logic [TAG_W-1:0]        tag;
      logic                    dbz;
   } calc_rsp_t;

   // One issue slot travelling alongside the calculator pipeline.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             dbz;
   } calc_trk_t;
endpackage

// File: rtl/calc_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is visible while not empty.
module calc_rsp_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  calc_rsp_t                  wr_data_i,
   input  logic                       rd_en_i,
   output calc_rsp_t                  rd_data_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   calc_rsp_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_wr;
   logic          do_rd;

   assign empty_o = (count_q == '0);
   assign do_rd   = rd_en_i && !empty_o;
   assign do_wr   = wr_en_i && (count_q != CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o   = count_q;
endmodule

// File: rtl/calc_driver.sv
// Issues requests to a fixed-latency calculator, tracks slots in flight and
// buffers results in a credit-protected FIFO, with a flush/drain mode.
module calc_driver
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int CALC_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic signed [OPND_W-1:0] req_a,
   input  logic signed [OPND_W-1:0] req_b,
   input  logic [TAG_W-1:0]         req_tag,
   output logic [1:0]               calc_function_out,
   output logic [OPND_W-1:0]        calc_a_out,
   output logic [OPND_W-1:0]        calc_b_out,
   input  logic signed [RES_W-1:0]  calc_result_in,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic signed [RES_W-1:0]  rsp_result,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic                     rsp_dbz,
   input  logic                     flush,
   output logic                     busy
);
   localparam int TD = CALC_LATENCY + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   drv_state_e        state_q, state_d;
   calc_trk_t         trk_q [TD];
   logic [1:0]        fn_q;
   logic [OPND_W-1:0] a_q, b_q;
   logic [31:0]       inflight_count;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              credit_ok;
   logic              accept;
   logic              req_dbz;
   calc_rsp_t         cap_data;
   calc_rsp_t         head;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < TD; i++) begin
         inflight_count = inflight_count + 32'(trk_q[i].valid);
      end
   end

   // Credit covers both buffered and in-flight work; a same-cycle pop is ignored.
   assign credit_ok = (32'(fifo_count) + inflight_count) < 32'(FIFO_DEPTH);
   assign req_ready = rst_n && (state_q == RUN) && !flush && credit_ok;
   assign accept    = req_valid && req_ready;
   assign req_dbz   = (calc_op_e'(req_op) == OP_DIV) && (req_b == '0);
   assign busy      = (inflight_count != '0) || (fifo_count != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if ((inflight_count == '0) && fifo_empty) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         fn_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         for (int i = 0; i < TD; i++) begin
            trk_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         fn_q     <= accept ? req_op : 2'b00;
         a_q      <= accept ? req_a  : '0;
         b_q      <= accept ? req_b  : '0;
         trk_q[0] <= '{valid: accept, tag: (accept ? req_tag : '0), dbz: (accept && req_dbz)};
         for (int i = 1; i < TD; i++) begin
            trk_q[i] <= trk_q[i-1];
         end
      end
   end

   assign calc_function_out = fn_q;
   assign calc_a_out        = a_q;
   assign calc_b_out        = b_q;

   // The last tracking stage lines up with the calculator output.
   assign cap_data = '{result: calc_result_in, tag: trk_q[TD-1].tag, dbz: trk_q[TD-1].dbz};

   calc_rsp_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (trk_q[TD-1].valid),
      .wr_data_i (cap_data),
      .rd_en_i   (rsp_valid && rsp_ready),
      .rd_data_o (head),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign rsp_valid  = !fifo_empty;
   assign rsp_result = head.result;
   assign rsp_tag    = head.tag;
   assign rsp_dbz    = head.dbz;
endmodule

// File: tb/tb_calc_driver.sv
// Scoreboard bench for calc_driver with a behavioural fixed-latency calculator.
module tb_calc_driver;
   import calc_pkg::*;

   localparam int DEPTH = 8;
   localparam int LAT   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = 2'b00;
   logic signed [7:0] req_a = '0;
   logic signed [7:0] req_b = '0;
   logic [3:0]        req_tag = '0;
   logic [1:0]        calc_function_out;
   logic [7:0]        calc_a_out;
   logic [7:0]        calc_b_out;
   logic signed [15:0] calc_result_in;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic signed [15:0] rsp_result;
   logic [3:0]        rsp_tag;
   logic              rsp_dbz;
   logic              flush = 1'b0;
   logic              busy;

   calc_driver #(
      .FIFO_DEPTH   (DEPTH),
      .CALC_LATENCY (LAT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_op            (req_op),
      .req_a             (req_a),
      .req_b             (req_b),
      .req_tag           (req_tag),
      .calc_function_out (calc_function_out),
      .calc_a_out        (calc_a_out),
      .calc_b_out        (calc_b_out),
      .calc_result_in    (calc_result_in),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_result        (rsp_result),
      .rsp_tag           (rsp_tag),
      .rsp_dbz           (rsp_dbz),
      .flush             (flush),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int result;
      int tag;
      int dbz;
   } exp_t;

   exp_t sb_q[$];
   int   pop_cyc[$];
   int   n_pops = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int calc_ref(input logic [1:0] op, input logic signed [7:0] a,
                                   input logic signed [7:0] b);
      case (op)
         2'b00:   return int'(a) + int'(b);
         2'b01:   return int'(a) - int'(b);
         2'b10:   return int'(a) * int'(b);
         default: begin
            if (b == 0) return (a < 0) ? -32768 : 32767;
            return int'(a) / int'(b);
         end
      endcase
   endfunction

   // Calculator: LAT register stages from calc_* inputs to calc_result_in.
   logic signed [15:0] calc_pipe [LAT];
   always @(posedge clk) begin
      calc_pipe[0] <= 16'(calc_ref(calc_function_out, calc_a_out, calc_b_out));
      for (int i = 1; i < LAT; i++) calc_pipe[i] <= calc_pipe[i-1];
   end
   assign calc_result_in = calc_pipe[LAT-1];

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_rsp", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check_val("rsp_result", int'(rsp_result), e.result);
            check_val("rsp_tag", int'(rsp_tag), e.tag);
            check_val("rsp_dbz", int'(rsp_dbz), e.dbz);
            $display("rsp tag=%0d result=%0d dbz=%0d at cycle %0d", rsp_tag, rsp_result, rsp_dbz, cyc);
         end
         n_pops++;
         pop_cyc.push_back(cyc);
      end
   end

   task automatic push_exp(input int r, input int t, input int d);
      exp_t e;
      e.result = r;
      e.tag    = t;
      e.dbz    = d;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one request and return 1ns after the edge that accepted it.
   task automatic send(input logic [1:0] op, input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic [3:0] tag, input int er, input int ed);
      int n;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check_val("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_exp(er, int'(tag), ed);
      $display("req tag=%0d op=%0d a=%0d b=%0d at cycle %0d", tag, op, a, b, cyc);
      #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("drain_timeout", int'(sb_q.size() == 0 && !busy), 1);
   endtask

   int                accepts;
   int                base;
   int                sent;
   int                n_wait;
   logic [1:0]        t_op;
   logic signed [7:0] t_a;
   logic signed [7:0] t_b;

   initial begin
      // Reset state
      @(negedge clk);
      check_val("rst_req_ready", int'(req_ready), 0);
      check_val("rst_rsp_valid", int'(rsp_valid), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_calc_fn", int'(calc_function_out), 0);
      check_val("rst_rsp_result", int'(rsp_result), 0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // Single add with latency check
      send(2'b00, 8'sd100, 8'sd27, 4'd3, 127, 0);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_val("lat_not_yet", int'(rsp_valid), 0);
      @(negedge clk);
      check_val("lat_valid_e3", int'(rsp_valid), 1);
      step(1);
      wait_drain();

      // Back-to-back mul/sub/div
      pop_cyc.delete();
      send(2'b10, -8'sd128, -8'sd128, 4'd1, 16384, 0);
      send(2'b01, -8'sd128, 8'sd127, 4'd2, -255, 0);
      send(2'b11, -8'sd7, 8'sd2, 4'd4, -3, 0);
      req_valid = 1'b0;
      wait_drain();
      check_val("b2b_pops", pop_cyc.size(), 3);
      if (pop_cyc.size() == 3) begin
         check_val("b2b_gap1", pop_cyc[1] - pop_cyc[0], 1);
         check_val("b2b_gap2", pop_cyc[2] - pop_cyc[1], 1);
      end

      // Divide by zero saturation and the div overflow corner
      send(2'b11, 8'sd7, 8'sd0, 4'd5, 32767, 1);
      send(2'b11, -8'sd5, 8'sd0, 4'd6, -32768, 1);
      send(2'b11, -8'sd128, -8'sd1, 4'd7, 128, 0);
      req_valid = 1'b0;
      wait_drain();

      // Backpressure: credit limit with rsp_ready low
      rsp_ready = 1'b0;
      accepts = 0;
      for (int k = 0; k < 20; k++) begin
         t_op = 2'(accepts % 4);
         t_a  = 8'(accepts * 13 - 50);
         t_b  = 8'(accepts - 3);
         req_valid = 1'b1;
         req_op    = t_op;
         req_a     = t_a;
         req_b     = t_b;
         req_tag   = 4'(accepts);
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            push_exp(calc_ref(t_op, t_a, t_b), accepts, int'(t_op == 2'b11 && t_b == 0));
            $display("req tag=%0d op=%0d a=%0d b=%0d at cycle %0d", accepts, t_op, t_a, t_b, cyc);
            accepts++;
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      req_valid = 1'b0;
      check_val("bp_accepts", accepts, 8);
      @(negedge clk);
      check_val("bp_ready_low", int'(req_ready), 0);
      check_val("bp_rsp_valid", int'(rsp_valid), 1);
      check_val("bp_head_tag", int'(rsp_tag), sb_q[0].tag);
      check_val("bp_head_res", int'(rsp_result), sb_q[0].result);
      repeat (3) @(negedge clk);
      check_val("bp_hold_tag", int'(rsp_tag), sb_q[0].tag);
      check_val("bp_hold_res", int'(rsp_result), sb_q[0].result);
      step(1);
      base = n_pops;
      rsp_ready = 1'b1;
      wait_drain();
      check_val("bp_delivered", n_pops - base, 8);

      // Flush with three in flight; flush+valid together must not accept
      base = n_pops;
      send(2'b00, 8'sd1, 8'sd1, 4'd1, 2, 0);
      send(2'b00, 8'sd2, 8'sd2, 4'd2, 4, 0);
      send(2'b00, 8'sd3, 8'sd3, 4'd3, 6, 0);
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_a     = 8'sd50;
      req_b     = 8'sd8;
      req_tag   = 4'd9;
      flush     = 1'b1;
      @(negedge clk);
      check_val("flush_blocks", int'(req_ready), 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      n_wait = 0;
      @(negedge clk);
      while (!req_ready && n_wait < 60) begin
         @(negedge clk);
         n_wait++;
      end
      check_val("drain_resume", int'(req_ready), 1);
      check_val("ready_while_busy", int'(busy), 0);
      check_val("flush_delivered", n_pops - base, 3);
      if (req_ready) begin
         @(posedge clk);
         push_exp(42, 9, 0);
         #1;
      end
      req_valid = 1'b0;
      wait_drain();

      // Reset mid-operation drops in-flight work
      send(2'b00, 8'sd10, 8'sd10, 4'd10, 20, 0);
      send(2'b00, 8'sd11, 8'sd11, 4'd11, 22, 0);
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      check_val("mrst_req_ready", int'(req_ready), 0);
      check_val("mrst_rsp_valid", int'(rsp_valid), 0);
      check_val("mrst_busy", int'(busy), 0);
      check_val("mrst_calc_fn", int'(calc_function_out), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rel_ready", int'(req_ready), 1);
      base = n_pops;
      step(6);
      check_val("rel_no_rsp", n_pops - base, 0);
      send(2'b10, 8'sd12, -8'sd3, 4'd12, -36, 0);
      req_valid = 1'b0;
      wait_drain();
      check_val("rel_fresh", n_pops - base, 1);

      // Random traffic with random backpressure
      sent = 0;
      for (int k = 0; k < 150; k++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_valid = (sent < 30) && ($urandom_range(0, 1) == 1);
         t_op = 2'($urandom_range(0, 3));
         t_a  = 8'($urandom);
         t_b  = ($urandom_range(0, 3) == 0) ? 8'sd0 : 8'($urandom);
         req_op  = t_op;
         req_a   = t_a;
         req_b   = t_b;
         req_tag = 4'(sent);
         @(negedge clk);
         if (req_valid && req_ready) begin
            @(posedge clk);
            push_exp(calc_ref(t_op, t_a, t_b), sent % 16, int'(t_op == 2'b11 && t_b == 0));
            $display("req tag=%0d op=%0d a=%0d b=%0d at cycle %0d", sent % 16, t_op, t_a, t_b, cyc);
            sent++;
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_drain();
      check_val("rand_sent", sent, 30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
